load_store_unit: RTL and testbench
==================================

# load_store_unit

MEM-stage load/store unit sitting directly upstream of the word-addressed main data memory. It accepts one access per cycle from the pipeline and issues word-aligned memory reads and writes. Sub-word loads (LB/LH/LBU/LHU) are aligned and extended. Sub-word stores (SB/SH) are converted into a two-cycle read-modify-write, with the pipeline stalled for the first cycle. Misaligned accesses are flagged and suppressed.

## Interface
Parameters: none.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  MEM stage holds a valid load/store this cycle
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, in bits [7:0] / [15:0] / [31:0]
- stall  out  1  pipeline must hold MEM-stage request stable next edge
- load_data  out  32  aligned, extended load result, combinational
- misaligned  out  1  current request misaligned; access suppressed
- mem_addr  out  32  {req_addr[31:2], 2'b00}
- mem_wdata  out  32  word to write
- MemWrite  out  1  memory write enable, committed at clk edge
- MemRead  out  1  memory read enable
- mem_rdata  in  32  memory read word, asynchronous

## Operation
- States: IDLE, MERGE. Register merge_word[31:0].
- Decode in IDLE with req_valid=1:
  - Misaligned: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]≠0. Assert misaligned=1 and no MemRead/MemWrite. load_data=0, stall=0, stay in IDLE.
  - Unsupported funct3 (loads 011/110/111; stores ≠000/001/010): no access, all outputs 0.
  - Load: MemRead=1. Select byte (addr[1:0]) or half (addr[1]) of mem_rdata. B/H sign-extend; BU/HU zero-extend; W is passed through. No stall.
  - SW: MemWrite=1, mem_wdata=req_wdata. No stall.
  - SB/SH: MemRead=1, stall=1. Register merge_word = mem_rdata with the target byte/half replaced by req_wdata[7:0]/[15:0]. Go to MERGE.
- MERGE: MemWrite=1, mem_wdata=merge_word, mem_addr from req_addr, which is still held. stall=0, so the pipeline advances at this edge. Next state is IDLE.
- Flush: req_valid=0 in MERGE suppresses MemWrite and returns to IDLE.
- req_valid=0 in IDLE: all outputs 0, state unchanged.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, merge_word=0. All outputs are 0 while reset is held.
- Reset asserted in MERGE aborts the write; no partial word is ever written.
- Loads, SW and misaligned requests take 1 cycle with zero stall. SB/SH take 2 cycles with exactly 1 stall cycle.
- stall, MemRead, MemWrite, mem_* and load_data are combinational from state and request. Only state and merge_word are registered.
- Back-to-back SB, SB: each costs 2 cycles. The second starts its read in the cycle after MERGE, so it observes the first write.
- Byte lanes are little-endian: addr[1:0]=0 selects bits [7:0], 3 selects [31:24]. Halves: addr[1]=0 selects [15:0].

## Test plan
- Word 0x100 = 0x8899AABB. LB at 0x103 → load_data 0xFFFFFF88. LBU at 0x103 → 0x00000088. LH at 0x102 → 0xFFFF8899. All with stall=0.
- SB 0x5A to 0x101 over 0x11223344 → cycle 1: stall=1, MemRead=1. Cycle 2: MemWrite=1, mem_wdata 0x11225A44, then IDLE.
- SH 0xBEEF at 0x202 then LW 0x200 over 0x00000000 → 0xBEEF0000. SW 0xCAFEF00D at 0x204 writes in 1 cycle with no stall.
- LW at 0x102 and SH at 0x301 → misaligned=1, MemRead=MemWrite=0, stall=0, memory unchanged.
- SB issued, then req_valid dropped in MERGE → MemWrite=0, word unchanged. Separately, rst_n pulsed low in MERGE → state IDLE, no write, all outputs 0.
- Back-to-back SB 0x01 at 0x300 and SB 0x02 at 0x301 over 0 → final word 0x00000201; exactly 2 stall cycles in total.

Source files
------------

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: word-aligned memory accesses, sub-word load extraction,
// and a two-cycle read-modify-write for byte and halfword stores.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [0:0] {StIdle, StMerge} state_e;

  state_e      state_q, state_d;
  logic [31:0] merge_word_q, merge_word_d;

  logic        fn_ok;
  logic        is_misal;
  logic        sub_store;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic [31:0] word_addr;

  assign word_addr = {req_addr[31:2], 2'b00};

  // Request decode
  always_comb begin
    if (req_write) begin
      fn_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      fn_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
              (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
    is_misal  = fn_ok && (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
    sub_store = req_write && fn_ok && !is_misal && (req_funct3[1:0] != 2'b10);
  end

  // Little-endian lane extraction and extension
  always_comb begin
    byte_sel = mem_rdata[{req_addr[1:0], 3'b000} +: 8];
    half_sel = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (req_funct3)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_ext = mem_rdata;
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = 32'h0;
    endcase
  end

  // Replace the target lane of the word just read with the store data
  always_comb begin
    merged = mem_rdata;
    if (req_funct3[0]) begin
      merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
    end else begin
      merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      merge_word_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      merge_word_q <= merge_word_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    merge_word_d = merge_word_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && sub_store) begin
          state_d      = StMerge;
          merge_word_d = merged;
        end
      end
      StMerge: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced low while reset is held so an aborted merge never writes
  always_comb begin
    stall      = 1'b0;
    load_data  = 32'h0;
    misaligned = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    MemWrite   = 1'b0;
    MemRead    = 1'b0;
    if (rst_n && req_valid) begin
      unique case (state_q)
        StIdle: begin
          if (is_misal) begin
            misaligned = 1'b1;
          end else if (fn_ok) begin
            mem_addr = word_addr;
            if (!req_write) begin
              MemRead   = 1'b1;
              load_data = load_ext;
            end else if (sub_store) begin
              MemRead = 1'b1;
              stall   = 1'b1;
            end else begin
              MemWrite  = 1'b1;
              mem_wdata = req_wdata;
            end
          end
        end
        StMerge: begin
          MemWrite  = 1'b1;
          mem_addr  = word_addr;
          mem_wdata = merge_word_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level reference model checked every
// cycle, plus hand-computed literal checks on loads, merged stores and memory contents.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        stall, misaligned, MemWrite, MemRead;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  load_store_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .load_data  (load_data),
    .misaligned (misaligned),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment memory seen by the DUT
  logic [31:0] mem [256];
  logic        mem_init = 1'b0;
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h40] <= 32'h8899AABB;
      mem_init   <= 1'b1;
    end else if (MemWrite) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: access rules expressed as byte arithmetic on a golden memory
  function automatic int unsigned acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit fn_valid(input logic w, input logic [2:0] f3);
    if (w) return f3 <= 3'd2;
    return (f3 <= 3'd5) && (f3 != 3'd3);
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] word, input logic [31:0] a,
                                           input logic [2:0] f3);
    int unsigned n = acc_size(f3);
    logic [31:0] m, v;
    if (n == 4) return word;
    m = (n == 1) ? 32'hFF : 32'hFFFF;
    v = (word >> {a[1:0], 3'b000}) & m;
    if (!f3[2] && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] merge_val(input logic [31:0] word, input logic [31:0] a,
                                            input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] m;
    m = ((acc_size(f3) == 1) ? 32'hFF : 32'hFFFF) << {a[1:0], 3'b000};
    return (word & ~m) | ((d << {a[1:0], 3'b000}) & m);
  endfunction

  logic [31:0] ref_mem [256];
  logic        ref_init = 1'b0;
  logic        phase = 1'b0;      // 1 = second cycle of a sub-word store
  logic        nxt_phase = 1'b0;
  logic        pend_wr = 1'b0;
  logic [7:0]  pend_idx = 8'h0;
  logic [31:0] pend_data = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!ref_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] <= 32'h0;
      ref_mem[8'h40] <= 32'h8899AABB;
      ref_init <= 1'b1;
      phase    <= 1'b0;
    end else if (!rst_n) begin
      phase <= 1'b0;
    end else begin
      phase <= nxt_phase;
      if (pend_wr) ref_mem[pend_idx] <= pend_data;
    end
  end

  always @(negedge clk) begin
    logic        e_stall, e_rd, e_wr, e_mis, chk_addr, chk_wd;
    logic [31:0] e_ld, e_addr, e_wd;
    int unsigned n;
    e_stall = 0; e_rd = 0; e_wr = 0; e_mis = 0; chk_addr = 0; chk_wd = 0;
    e_ld = 0; e_addr = {req_addr[31:2], 2'b00}; e_wd = 0;
    nxt_phase = 0; pend_wr = 0;
    pend_idx = req_addr[9:2];
    if (rst_n && req_valid) begin
      if (phase) begin
        e_wr = 1; chk_addr = 1; chk_wd = 1;
        e_wd = merge_val(ref_mem[req_addr[9:2]], req_addr, req_funct3, req_wdata);
        pend_wr = 1; pend_data = e_wd;
      end else if (fn_valid(req_write, req_funct3)) begin
        n = acc_size(req_funct3);
        if ((req_addr & (n - 1)) != 0) begin
          e_mis = 1;
        end else if (!req_write) begin
          e_rd = 1; chk_addr = 1;
          e_ld = load_val(ref_mem[req_addr[9:2]], req_addr, req_funct3);
        end else if (n == 4) begin
          e_wr = 1; chk_addr = 1; chk_wd = 1; e_wd = req_wdata;
          pend_wr = 1; pend_data = req_wdata;
        end else begin
          e_rd = 1; e_stall = 1; chk_addr = 1; nxt_phase = 1;
        end
      end
    end
    check("model stall", {31'h0, stall}, {31'h0, e_stall});
    check("model MemRead", {31'h0, MemRead}, {31'h0, e_rd});
    check("model MemWrite", {31'h0, MemWrite}, {31'h0, e_wr});
    check("model misaligned", {31'h0, misaligned}, {31'h0, e_mis});
    check("model load_data", load_data, e_ld);
    if (chk_addr) check("model mem_addr", mem_addr, e_addr);
    if (chk_wd) check("model mem_wdata", mem_wdata, e_wd);
  end

  // Stimulus with per-cycle capture for literal checks
  logic        cap_stall [2];
  logic        cap_rd [2];
  logic        cap_wr [2];
  logic        cap_mis [2];
  logic [31:0] cap_wd [2];
  logic [31:0] cap_ld [2];
  int          stall_cnt = 0;

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int cyc);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      cap_stall[i] = stall; cap_rd[i] = MemRead; cap_wr[i] = MemWrite;
      cap_mis[i] = misaligned; cap_wd[i] = mem_wdata; cap_ld[i] = load_data;
      if (stall) stall_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Valid load presented during reset must produce no activity
    req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100;
    @(negedge clk);
    check("reset MemRead", {31'h0, MemRead}, 32'h0);
    check("reset load_data", load_data, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle();

    do_req(1'b0, 3'b000, 32'h103, 32'h0, 1);
    check("LB 0x103 load_data", cap_ld[0], 32'hFFFFFF88);
    check("LB 0x103 stall", {31'h0, cap_stall[0]}, 32'h0);
    do_req(1'b0, 3'b100, 32'h103, 32'h0, 1);
    check("LBU 0x103 load_data", cap_ld[0], 32'h00000088);
    do_req(1'b0, 3'b001, 32'h102, 32'h0, 1);
    check("LH 0x102 load_data", cap_ld[0], 32'hFFFF8899);
    check("LH 0x102 stall", {31'h0, cap_stall[0]}, 32'h0);
    do_req(1'b0, 3'b101, 32'h100, 32'h0, 1);
    check("LHU 0x100 load_data", cap_ld[0], 32'h0000AABB);
    do_req(1'b0, 3'b000, 32'h101, 32'h0, 1);
    check("LB 0x101 load_data", cap_ld[0], 32'hFFFFFFAA);

    // Unsupported funct3: load 011, store 100
    do_req(1'b0, 3'b011, 32'h100, 32'h0, 1);
    check("LD? unsupported MemRead", {31'h0, cap_rd[0]}, 32'h0);
    do_req(1'b1, 3'b100, 32'h100, 32'h0, 1);
    check("S? unsupported MemWrite", {31'h0, cap_wr[0]}, 32'h0);

    do_req(1'b1, 3'b010, 32'h100, 32'h11223344, 1);
    do_req(1'b1, 3'b000, 32'h101, 32'h0000005A, 2);
    check("SB cycle1 stall", {31'h0, cap_stall[0]}, 32'h1);
    check("SB cycle1 MemRead", {31'h0, cap_rd[0]}, 32'h1);
    check("SB cycle2 MemWrite", {31'h0, cap_wr[1]}, 32'h1);
    check("SB cycle2 mem_wdata", cap_wd[1], 32'h11225A44);
    check("SB cycle2 stall", {31'h0, cap_stall[1]}, 32'h0);
    idle();
    check("SB word 0x100", mem[8'h40], 32'h11225A44);

    do_req(1'b1, 3'b001, 32'h202, 32'h0000BEEF, 2);
    do_req(1'b0, 3'b010, 32'h200, 32'h0, 1);
    check("SH+LW 0x200 load_data", cap_ld[0], 32'hBEEF0000);
    do_req(1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 1);
    check("SW 0x204 stall", {31'h0, cap_stall[0]}, 32'h0);
    check("SW 0x204 MemWrite", {31'h0, cap_wr[0]}, 32'h1);
    idle();
    check("SW word 0x204", mem[8'h81], 32'hCAFEF00D);

    do_req(1'b0, 3'b010, 32'h102, 32'h0, 1);
    check("LW 0x102 misaligned", {31'h0, cap_mis[0]}, 32'h1);
    check("LW 0x102 MemRead", {31'h0, cap_rd[0]}, 32'h0);
    do_req(1'b1, 3'b001, 32'h301, 32'h0000FFFF, 1);
    check("SH 0x301 misaligned", {31'h0, cap_mis[0]}, 32'h1);
    check("SH 0x301 MemWrite", {31'h0, cap_wr[0]}, 32'h0);
    check("SH 0x301 stall", {31'h0, cap_stall[0]}, 32'h0);
    idle();
    check("misaligned word 0x300", mem[8'hC0], 32'h0);

    // Flush in MERGE
    do_req(1'b1, 3'b000, 32'h200, 32'h00000077, 1);
    req_valid = 1'b0;
    @(negedge clk);
    check("flush MemWrite", {31'h0, MemWrite}, 32'h0);
    @(posedge clk); #1;
    idle();
    check("flush word 0x200", mem[8'h80], 32'hBEEF0000);

    // Reset in MERGE
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h204; req_wdata = 32'h66;
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk);
    check("reset-in-merge MemWrite", {31'h0, MemWrite}, 32'h0);
    check("reset-in-merge mem_wdata", mem_wdata, 32'h0);
    check("reset-in-merge stall", {31'h0, stall}, 32'h0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    check("reset-in-merge word 0x204", mem[8'h81], 32'hCAFEF00D);

    // Back-to-back byte stores
    stall_cnt = 0;
    do_req(1'b1, 3'b000, 32'h300, 32'h01, 2);
    do_req(1'b1, 3'b000, 32'h301, 32'h02, 2);
    idle();
    check("b2b word 0x300", mem[8'hC0], 32'h00000201);
    check("b2b stall cycles", stall_cnt, 32'd2);

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
